if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/if_fetch_unit_if.sv | 28 ++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/if_fetch_unit.sv | 102 ++++++++++
 tb/tb_if_fetch_unit.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FETCH_PREDECODE_EN adds a per-entry "unsupported opcode" flag to the FIFO entry.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam int FIFO_DEPTH = 2;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
`ifdef FETCH_PREDECODE_EN
        logic        unsup;
`endif
        logic [31:0] pc;
        logic [31:0] inst;
    } fifo_entry_t;

`ifdef FETCH_PREDECODE_EN
    function automatic logic opcode_unsupported(input logic [6:0] opc);
        return !(opc inside {OPC_OP, OPC_LOAD, OPC_STORE, OPC_BRANCH});
    endfunction
`endif

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory and decode-side signals of the fetch unit.
// master = fetch unit, slave = memory/decode environment.
interface if_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_unsup;
    logic        dec_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, inst, inst_pc, inst_valid, inst_unsup,
        input  imem_gnt, imem_rvalid, imem_rdata, dec_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst, inst_pc, inst_valid, inst_unsup,
        output imem_gnt, imem_rvalid, imem_rdata, dec_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small instruction buffer between fetch and decode; flush discards all entries.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_push,
    input  fifo_entry_t i_wdata,
    input  logic        i_pop,
    input  logic        i_flush,
    output fifo_entry_t o_rdata,
    output logic        o_full,
    output logic        o_empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    fifo_entry_t      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = (r_count == DEPTH_C);
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/if_fetch_unit.sv
// Single-outstanding instruction fetcher with a 2-entry buffer; FETCH_PREDECODE_EN enables inst_unsup.
// States: IDLE wait for buffer space | REQ request out | WAIT awaiting rdata | DRAIN discard stale rdata.
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    if_fetch_unit_if.master   bus
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_fetch_pc;
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    fifo_entry_t  w_wentry;
    fifo_entry_t  w_head;

    // Redirect wins over everything: it blocks the push and the pop and flushes the buffer.
    assign w_push = (r_state == WAIT) && bus.imem_rvalid && !bus.redirect;
    assign w_pop  = !w_empty && bus.dec_ready && !bus.redirect;

    always_comb begin
        w_wentry      = '0;
        w_wentry.inst = bus.imem_rdata;
        w_wentry.pc   = r_fetch_pc;
`ifdef FETCH_PREDECODE_EN
        w_wentry.unsup = opcode_unsupported(bus.imem_rdata[6:0]);
`endif
    end

    fetch_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_wentry),
        .i_pop   (w_pop),
        .i_flush (bus.redirect),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC & ~32'h3;
        end else if (bus.redirect) begin
            r_fetch_pc <= bus.redirect_pc & ~32'h3;
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
        end
    end

    // Nothing is outstanding in IDLE, so "occupancy + outstanding < 2" reduces to "not full".
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (!bus.redirect && !w_full) w_state_nxt = REQ;
            end
            REQ: begin
                if (bus.redirect)      w_state_nxt = IDLE;
                else if (bus.imem_gnt) w_state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.redirect)         w_state_nxt = bus.imem_rvalid ? IDLE : DRAIN;
                else if (bus.imem_rvalid) w_state_nxt = IDLE;
            end
            DRAIN: begin
                if (bus.imem_rvalid) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The request is withdrawn in a redirect cycle so a same-cycle grant is never a handshake.
    always_comb begin
        bus.imem_req   = (r_state == REQ) && !bus.redirect;
        bus.imem_addr  = r_fetch_pc;
        bus.inst       = w_head.inst;
        bus.inst_pc    = w_head.pc;
        bus.inst_valid = !w_empty;
`ifdef FETCH_PREDECODE_EN
        bus.inst_unsup = !w_empty && w_head.unsup;
`else
        bus.inst_unsup = 1'b0;
`endif
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed fetch, stall, redirect, wrap and reset scenarios.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef FETCH_PREDECODE_EN
    localparam bit PREDECODE = 1'b1;
`else
    localparam bit PREDECODE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    if_fetch_unit_if bus();

    if_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    int          budget   = 0;
    int          rv_delay = 1;
    int          hs_count = 0;

    // Memory contents: opcode chosen by addr[3:2]; only 0010011 is outside the supported set.
    function automatic logic [6:0] opc_of(input logic [31:0] a);
        case (a[3:2])
            2'd0:    return 7'b0110011;
            2'd1:    return 7'b0000011;
            2'd2:    return 7'b0010011;
            default: return 7'b1100011;
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[26:2], opc_of(a)};
    endfunction

    function automatic logic exp_unsup(input logic [31:0] a);
        return PREDECODE && (opc_of(a) == 7'b0010011);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input int limit, input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < limit) begin
            @(negedge clk);
            #1;
            i++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d responses still expected after %0d cycles", name, exp_q.size(), limit);
            exp_q.delete();
        end
    endtask

    task automatic wait_hs(input int target, input int limit, input string name);
        int i;
        i = 0;
        while (hs_count < target && i < limit) begin
            @(negedge clk);
            #1;
            i++;
        end
        check(name, 32'(hs_count), 32'(target));
    endtask

    task automatic wait_req(input int limit, input string name, input logic [31:0] exp_addr);
        logic found;
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (bus.imem_req) found = 1'b1;
            else check({name, " inst_valid before refetch"}, 32'(bus.inst_valid), 32'd0);
        end
        check({name, " refetch issued"}, 32'(found), 32'd1);
        check({name, " refetch addr"}, bus.imem_addr, exp_addr);
    endtask

    // Memory model: grants while budget lasts, returns data rv_delay cycles after the handshake.
    initial begin : mem_model
        logic        pend;
        int          pend_cnt;
        logic [31:0] pend_addr;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        pend      = 1'b0;
        pend_cnt  = 0;
        pend_addr = '0;
        forever begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_gnt) begin
                pend      = 1'b1;
                pend_cnt  = rv_delay;
                pend_addr = bus.imem_addr;
                hs_count++;
                budget--;
            end
            @(posedge clk);
            #1;
            bus.imem_rvalid = 1'b0;
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem_word(pend_addr);
                    pend = 1'b0;
                end
            end
            bus.imem_gnt = (budget > 0);
        end
    end

    // Monitor: pops the scoreboard on every accepted instruction and checks hold during stalls.
    initial begin : monitor
        logic        stall;
        logic [31:0] s_pc;
        logic [31:0] s_inst;
        logic [31:0] e;
        stall  = 1'b0;
        s_pc   = '0;
        s_inst = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.inst_valid) begin
                if (stall) begin
                    check("hold inst_pc", bus.inst_pc, s_pc);
                    check("hold inst", bus.inst, s_inst);
                end
                if (bus.dec_ready && !bus.redirect) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected delivery: inst_pc %h, nothing expected", bus.inst_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("deliver inst_pc", bus.inst_pc, e);
                        check("deliver inst", bus.inst, mem_word(e));
                        check("deliver inst_unsup", 32'(bus.inst_unsup), 32'(exp_unsup(e)));
                    end
                end
            end
            stall  = rst_n && bus.inst_valid && !bus.dec_ready && !bus.redirect;
            s_pc   = bus.inst_pc;
            s_inst = bus.inst;
        end
    end

    initial begin : stimulus
        int hs0;
        rst_n           = 1'b0;
        bus.dec_ready   = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;

        // Reset state
        repeat (3) step();
        @(negedge clk);
        check("reset inst_valid", 32'(bus.inst_valid), 32'd0);
        check("reset imem_req", 32'(bus.imem_req), 32'd0);
        check("reset inst", bus.inst, 32'd0);
        check("reset inst_pc", bus.inst_pc, 32'd0);
        check("reset inst_unsup", 32'(bus.inst_unsup), 32'd0);

        // Straight-line fetch from RESET_PC
        step();
        budget = 3;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        rst_n = 1'b1;
        step();
        @(negedge clk);
        check("first imem_req after reset", 32'(bus.imem_req), 32'd1);
        check("first imem_addr", bus.imem_addr, 32'h100);
        wait_drain(50, "sequential fetch");
        repeat (3) step();
        @(negedge clk);
        check("next request pending", 32'(bus.imem_req), 32'd1);
        check("next request addr", bus.imem_addr, 32'h10C);

        // Decode stall: buffer fills to 2 and fetch stops
        step();
        bus.dec_ready = 1'b0;
        hs0 = hs_count;
        budget = 5;
        for (int a = 32'h10C; a <= 32'h11C; a += 4) exp_q.push_back(32'(a));
        repeat (10) step();
        @(negedge clk);
        check("stall inst_valid", 32'(bus.inst_valid), 32'd1);
        check("stall head inst_pc", bus.inst_pc, 32'h10C);
        check("stall head inst", bus.inst, mem_word(32'h10C));
        check("stall handshakes", 32'(hs_count - hs0), 32'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check("stall imem_req low", 32'(bus.imem_req), 32'd0);
        end
        step();
        bus.dec_ready = 1'b1;
        wait_drain(60, "stall release");

        // Redirect while waiting for data: stale rdata must be drained
        step();
        rv_delay = 3;
        budget   = 1;
        wait_hs(hs_count + 1, 20, "wait-state handshake");
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0203;
        step();
        bus.redirect = 1'b0;
        budget   = 1;
        rv_delay = 1;
        exp_q.push_back(32'h200);
        wait_req(15, "redirect in WAIT", 32'h200);
        wait_drain(30, "redirect in WAIT");

        // Redirect with same-cycle rvalid, landing on the top word to exercise the wrap
        step();
        budget = 1;
        wait_hs(hs_count + 1, 20, "rvalid-redirect handshake");
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        step();
        bus.redirect = 1'b0;
        budget = 2;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        @(negedge clk);
        check("same-cycle redirect empties buffer", 32'(bus.inst_valid), 32'd0);
        wait_req(15, "redirect with rvalid", 32'hFFFF_FFFC);
        wait_drain(30, "address wrap");
        repeat (3) step();
        @(negedge clk);
        check("after wrap imem_addr", bus.imem_addr, 32'h0000_0004);

        // Reset while a request is outstanding; its late rvalid must be ignored
        step();
        rv_delay = 3;
        budget   = 1;
        wait_hs(hs_count + 1, 20, "pre-reset handshake");
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("mid reset imem_req", 32'(bus.imem_req), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            check("late rvalid ignored", 32'(bus.inst_valid), 32'd0);
        end
        check("post reset imem_req", 32'(bus.imem_req), 32'd1);
        check("post reset imem_addr", bus.imem_addr, RST_PC);
        step();
        rv_delay = 1;
        budget   = 1;
        exp_q.push_back(32'h100);
        wait_drain(30, "post reset fetch");

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
